// File: rtl/keypad_capture_fsm_pkg.sv
// Shared timer-input definitions: FSM state encodings, BCD width and release-counter helpers.
package keypad_capture_fsm_pkg;

    localparam int unsigned BCD_W   = 4;
    localparam int unsigned STATE_W = 2;
    localparam int unsigned CNT_W   = 4;

    localparam logic [STATE_W-1:0] IDLE     = 2'd0;
    localparam logic [STATE_W-1:0] DEBOUNCE = 2'd1;
    localparam logic [STATE_W-1:0] EMIT     = 2'd2;
    localparam logic [STATE_W-1:0] HOLD     = 2'd3;

    typedef logic [BCD_W-1:0] bcd_t;
    typedef logic [CNT_W-1:0] cnt_t;

    // Saturating increment so the release counter can never wrap back to zero.
    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/keypad_capture_fsm_if.sv
// Keypad capture bus: raw key lines and debounce handshake in, accepted BCD digit out.
interface keypad_capture_fsm_if #(
    parameter int unsigned NUM_KEYS = 10
);
    import keypad_capture_fsm_pkg::*;

    logic [NUM_KEYS-1:0] keypad;
    logic                debounce_edge;
    logic                debounce_start;
    bcd_t                digit;
    logic                digit_valid;
    logic                busy;

    modport master (
        output keypad,
        output debounce_edge,
        input  debounce_start,
        input  digit,
        input  digit_valid,
        input  busy
    );

    modport slave (
        input  keypad,
        input  debounce_edge,
        output debounce_start,
        output digit,
        output digit_valid,
        output busy
    );

endinterface

// File: rtl/keypad_capture_fsm_key_priority_encoder.sv
// Combinational keypad encoder: highest active line index wins, plus an any-key flag.
module key_priority_encoder
    import keypad_capture_fsm_pkg::*;
#(
    parameter int unsigned NUM_KEYS = 10
) (
    input  logic [NUM_KEYS-1:0] keypad,
    output bcd_t                code_c,
    output logic                any_key_c
);

    // Ascending scan so later (higher) indices overwrite lower ones.
    always_comb begin
        code_c = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (keypad[i]) begin
                code_c = BCD_W'(i);
            end
        end
    end

    assign any_key_c = |keypad;

endmodule

// File: rtl/keypad_capture_fsm.sv
// Keypad capture FSM: latch a key, wait for the debounce delay, strobe one BCD digit, re-arm on release.
module keypad_capture_fsm
    import keypad_capture_fsm_pkg::*;
#(
    parameter int unsigned NUM_KEYS       = 10,
    parameter int unsigned RELEASE_CYCLES = 4
) (
    input  logic                 clock,
    input  logic                 clear,
    keypad_capture_fsm_if.slave  bus
);

    localparam cnt_t RELEASE_LAST = CNT_W'(RELEASE_CYCLES - 1);

    logic [STATE_W-1:0] state_q, state_d;
    bcd_t               cur_key_q, cur_key_d;
    cnt_t               cnt_q, cnt_d;
    bcd_t               digit_q, digit_d;
    logic               valid_q, valid_d;
    logic               start_q, start_d;
    logic               busy_q, busy_d;

    bcd_t               code;
    logic               any_key;

    key_priority_encoder #(
        .NUM_KEYS (NUM_KEYS)
    ) u_enc (
        .keypad    (bus.keypad),
        .code_c    (code),
        .any_key_c (any_key)
    );

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q   <= IDLE;
            cur_key_q <= '0;
            cnt_q     <= '0;
            digit_q   <= '0;
            valid_q   <= 1'b0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_key_q <= cur_key_d;
            cnt_q     <= cnt_d;
            digit_q   <= digit_d;
            valid_q   <= valid_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
        end
    end

    // Outputs are computed from the next state so they register alongside it.
    always_comb begin
        state_d   = state_q;
        cur_key_d = cur_key_q;
        cnt_d     = cnt_q;
        digit_d   = digit_q;
        valid_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_key) begin
                    cur_key_d = code;
                    state_d   = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                // Losing or changing the key wins over a coincident debounce edge.
                if (!any_key || (code != cur_key_q)) begin
                    state_d = IDLE;
                end else if (bus.debounce_edge) begin
                    state_d = EMIT;
                    digit_d = cur_key_q;
                    valid_d = 1'b1;
                end
            end
            EMIT: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (any_key) begin
                    cnt_d = '0;
                end else if (cnt_q >= RELEASE_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        start_d = (state_d == DEBOUNCE);
        busy_d  = (state_d != IDLE);
    end

    assign bus.debounce_start = start_q;
    assign bus.digit          = digit_q;
    assign bus.digit_valid    = valid_q;
    assign bus.busy           = busy_q;

endmodule

// File: tb/tb_keypad_capture_fsm.sv
// Directed bench for keypad_capture_fsm with hand-computed expectations per step.
module tb_keypad_capture_fsm;

    logic clock;
    logic clear;
    int   vectors;
    int   miscompares;

    keypad_capture_fsm_if #(.NUM_KEYS(10)) bus ();

    keypad_capture_fsm #(
        .NUM_KEYS       (10),
        .RELEASE_CYCLES (4)
    ) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks all four outputs at once: start, valid, digit, busy.
    task automatic chk_all(input string tag, input logic s, input logic v, input logic [3:0] d, input logic b);
        chk({tag, ".start"}, 32'(bus.debounce_start), 32'(s));
        chk({tag, ".valid"}, 32'(bus.digit_valid), 32'(v));
        chk({tag, ".digit"}, 32'(bus.digit), 32'(d));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(b));
    endtask

    task automatic release_check(input string tag, input logic [3:0] d);
        bus.keypad = '0;
        repeat (3) tick();
        chk({tag, ".rel3_busy"}, 32'(bus.busy), 32'd1);
        tick();
        chk_all({tag, ".rel4"}, 1'b0, 1'b0, d, 1'b0);
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        clear         = 1'b1;
        bus.keypad    = 10'h004;
        bus.debounce_edge = 1'b0;

        // Reset held with a key pressed.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("reset", 1'b0, 1'b0, 4'd0, 1'b0);
        end
        clear      = 1'b0;
        bus.keypad = '0;
        tick();
        chk_all("idle", 1'b0, 1'b0, 4'd0, 1'b0);

        // Clean press of key 7.
        bus.keypad = 10'(1 << 7);
        tick();
        chk_all("press7", 1'b1, 1'b0, 4'd0, 1'b1);
        for (int i = 0; i < 19; i++) begin
            tick();
            chk({"press7.wait", ".start"}, 32'(bus.debounce_start), 32'd1);
        end
        bus.debounce_edge = 1'b1;
        tick();
        chk_all("emit7", 1'b0, 1'b1, 4'd7, 1'b1);
        bus.debounce_edge = 1'b0;
        tick();
        chk_all("hold7", 1'b0, 1'b0, 4'd7, 1'b1);
        release_check("k7", 4'd7);

        // Bounce on key 3.
        bus.keypad = 10'(1 << 3);
        tick();
        chk_all("b3.press", 1'b1, 1'b0, 4'd7, 1'b1);
        repeat (4) tick();
        bus.keypad = '0;
        tick();
        chk_all("b3.bounce", 1'b0, 1'b0, 4'd7, 1'b0);
        bus.keypad = 10'(1 << 3);
        tick();
        chk_all("b3.repress", 1'b1, 1'b0, 4'd7, 1'b1);
        repeat (3) tick();
        bus.debounce_edge = 1'b1;
        tick();
        chk_all("b3.emit", 1'b0, 1'b1, 4'd3, 1'b1);
        bus.debounce_edge = 1'b0;
        tick();
        chk_all("b3.hold", 1'b0, 1'b0, 4'd3, 1'b1);
        release_check("k3", 4'd3);

        // Key change 2 -> 5 during debounce.
        bus.keypad = 10'(1 << 2);
        repeat (3) tick();
        bus.keypad = 10'(1 << 5);
        tick();
        chk_all("chg.drop", 1'b0, 1'b0, 4'd3, 1'b0);
        tick();
        chk_all("chg.restart", 1'b1, 1'b0, 4'd3, 1'b1);
        bus.debounce_edge = 1'b1;
        tick();
        chk_all("chg.emit5", 1'b0, 1'b1, 4'd5, 1'b1);
        bus.debounce_edge = 1'b0;
        tick();
        release_check("k5", 4'd5);

        // Simultaneous keys 1 and 9 resolve to 9.
        bus.keypad = 10'((1 << 1) | (1 << 9));
        repeat (2) tick();
        bus.debounce_edge = 1'b1;
        tick();
        chk_all("multi.emit9", 1'b0, 1'b1, 4'd9, 1'b1);
        bus.debounce_edge = 1'b0;
        tick();
        release_check("k9", 4'd9);

        // Key 4 held: extra edges give no repeat strobes.
        bus.keypad = 10'(1 << 4);
        repeat (3) tick();
        bus.debounce_edge = 1'b1;
        tick();
        chk_all("k4.emit", 1'b0, 1'b1, 4'd4, 1'b1);
        bus.debounce_edge = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.debounce_edge = 1'b1;
            tick();
            chk_all("k4.norepeat_hi", 1'b0, 1'b0, 4'd4, 1'b1);
            bus.debounce_edge = 1'b0;
            tick();
            chk_all("k4.norepeat_lo", 1'b0, 1'b0, 4'd4, 1'b1);
        end
        // Two-cycle release glitch keeps HOLD; a new key is ignored in HOLD.
        bus.keypad = '0;
        repeat (2) tick();
        chk_all("k4.glitch", 1'b0, 1'b0, 4'd4, 1'b1);
        bus.keypad = 10'(1 << 4);
        tick();
        chk_all("k4.repress", 1'b0, 1'b0, 4'd4, 1'b1);
        bus.keypad = 10'(1 << 6);
        tick();
        chk_all("k4.newkey", 1'b0, 1'b0, 4'd4, 1'b1);
        release_check("k4", 4'd4);

        // Clear while debouncing key 8.
        bus.keypad = 10'(1 << 8);
        repeat (2) tick();
        chk_all("clr.deb", 1'b1, 1'b0, 4'd4, 1'b1);
        clear = 1'b1;
        bus.debounce_edge = 1'b1;
        tick();
        chk_all("clr.hit", 1'b0, 1'b0, 4'd0, 1'b0);
        clear = 1'b0;
        bus.debounce_edge = 1'b0;
        bus.keypad = '0;
        tick();
        chk_all("clr.after", 1'b0, 1'b0, 4'd0, 1'b0);

        // Release coincident with debounce edge: no strobe.
        bus.keypad = 10'(1 << 2);
        repeat (2) tick();
        chk_all("coin.deb", 1'b1, 1'b0, 4'd0, 1'b1);
        bus.keypad = '0;
        bus.debounce_edge = 1'b1;
        tick();
        chk_all("coin.drop", 1'b0, 1'b0, 4'd0, 1'b0);
        bus.debounce_edge = 1'b0;
        tick();
        chk_all("coin.after", 1'b0, 1'b0, 4'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/keypad_capture_fsm.md
Name: keypad_capture_fsm

Overview:
- Front-end stage of the timer input path; sits directly upstream of debounce_delay and consumes its result.
- Watches the 10-key numeric keypad (keys 0-9) and latches the pressed key.
- Starts a debounce run by driving debounce_delay's clear input; waits for its edge_out pulse.
- Then emits one BCD digit with a single-cycle valid strobe. Re-arms only after a confirmed release.
- Downstream digit-entry logic (MM:SS shift register) consumes digit/digit_valid.

Parameters:
- NUM_KEYS, 10, number of keypad lines; key index i encodes BCD value i.
- RELEASE_CYCLES, 4, consecutive all-released cycles required before re-arming (1..15).

Ports:
- clock  input  1  system clock; all logic on rising edge.
- clear  input  1  synchronous active-high reset.
- keypad  input  NUM_KEYS  raw key lines, active-high, already synchronised to clock.
- debounce_edge  input  1  edge_out from debounce_delay.
- debounce_start  output  1  drives debounce_delay's clear input. High holds the delay running; low resets it.
- digit  output  4  BCD code of the last accepted key.
- digit_valid  output  1  one-cycle strobe when digit is updated.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Interface: single clock `clock`. Reset `clear` is synchronous and active-high. When clear=1 at a rising edge, all state returns to reset values on that edge.
- Reset values:
  - state=IDLE, debounce_start=0, digit=4'd0, digit_valid=0, busy=0.
  - Latched key=0, release counter=0.
- Key encoding (combinational):
  - any_key = |keypad.
  - code = index of the highest set bit, so simultaneous keys resolve to the highest index.
- State IDLE:
  - If any_key, latch code into cur_key and go to DEBOUNCE.
  - debounce_start goes high on the same edge (registered output).
  - debounce_edge is ignored in IDLE.
- State DEBOUNCE:
  - debounce_start=1.
  - If !any_key or code != cur_key: go to IDLE and drop debounce_start. This resets debounce_delay. No strobe.
  - Else if debounce_edge=1: go to EMIT, load digit <= cur_key, and set digit_valid=1 on that edge.
  - Key loss takes priority over a coincident debounce_edge.
- State EMIT (exactly 1 cycle):
  - digit_valid=1, debounce_start=0. Unconditionally go to HOLD.
  - digit_valid is therefore high exactly one cycle.
  - Latency: edge_out sampled high at edge n gives digit_valid high from edge n to edge n+1.
- State HOLD:
  - Key still held; no further strobes (no auto-repeat).
  - Counter counts consecutive cycles with !any_key and resets to 0 whenever any_key=1.
  - When counter reaches RELEASE_CYCLES-1 with !any_key, go to IDLE and zero the counter.
  - A new key pressed while in HOLD is not captured until IDLE is re-entered.
- Counter width: 4 bits, saturating; no wrap is possible given the parameter range.
- digit holds its value across all states until the next EMIT. Only clear zeroes it.
- clear mid-DEBOUNCE: debounce_start drops on the same edge, and no digit_valid is issued.
- Out-of-range codes are not producible; digit is always 0-9.

Decomposition:
- Shared package/header (timer_input_defs): state encodings IDLE=2'd0, DEBOUNCE=2'd1, EMIT=2'd2, HOLD=2'd3, and the BCD width constant 4.
- One natural sub-module: key_priority_encoder. Combinational, NUM_KEYS-to-4 highest-index encoder plus any_key.
- FSM and release counter stay in the top module.

Test Plan:
- Reset: clear=1 for 3 cycles with keypad=10'h004 -> digit=0, digit_valid=0, debounce_start=0, busy=0 throughout.
- Clean press: keypad=1<<7 held, debounce_edge pulsed 20 cycles later -> debounce_start high from the cycle after the press until EMIT. digit=7; digit_valid high exactly one cycle, the cycle after the edge. Release for 4 cycles -> busy=0.
- Bounce: key 3 pressed 5 cycles, released 1 cycle, pressed again -> debounce_start drops for the release and re-asserts. Only one digit_valid with digit=3 after the eventual edge.
- Key change during debounce: key 2 then key 5 before edge -> return to IDLE, restart with cur_key=5, and the final digit=5. Simultaneous keys 1 and 9 -> digit=9.
- No repeat and release filter:
  - Hold key 4 through 3 extra debounce_edge pulses -> single strobe.
  - Release glitch of 2 cycles then re-press -> stays in HOLD.
  - 4 clean released cycles -> IDLE.
- Reset mid-debounce and coincidence:
  - clear asserted while in DEBOUNCE -> no strobe; digit keeps its reset value 0.
  - Key release on the same cycle as debounce_edge -> no strobe, state returns to IDLE.
